// File: rtl/usb_xfer_arb_if.sv
// usb_xfer_arb_if: requester and USB FIFO controller signals
// shared by usb_xfer_arb (slave) and its clients (master).
interface usb_xfer_arb_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_dir;
  logic [NUM_REQ*11-1:0] req_len;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    done;
  logic                  err_timeout;
  logic [1:0]            rd_wr_en;
  logic [10:0]           rd_wr_num;
  logic                  usb_is_busy;
  logic                  output_valid;
  logic                  write_ready;

  modport slave (
    input  req_valid, req_dir, req_len,
    input  usb_is_busy, output_valid,
    input  write_ready,
    output grant, done, err_timeout,
    output rd_wr_en, rd_wr_num
  );

  modport master (
    output req_valid, req_dir, req_len,
    output usb_is_busy, output_valid,
    output write_ready,
    input  grant, done, err_timeout,
    input  rd_wr_en, rd_wr_num
  );
endinterface

// File: rtl/usb_xfer_arb.sv
// usb_xfer_arb: round-robin USB FIFO burst arbiter with watchdog.
// Define USB_ARB_PRIO_EN to give requester 0 fixed top priority.
module usb_xfer_arb #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 4096,
  parameter int GAP_CYC     = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  usb_xfer_arb_if.slave bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE, ARB, XFER, GAP
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               err_q, err_d;
  logic [1:0]         en_q, en_d;
  logic [10:0]        num_q, num_d;
  logic [10:0]        len_q, len_d;
  logic [10:0]        beat_q, beat_d;
  logic [15:0]        wd_q, wd_d;
  logic [7:0]         gap_q, gap_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic               dir_q, dir_d;

  logic [NUM_REQ-1:0] cand, win_oh;
  logic [IW-1:0]      win, idx;
  logic               win_ok, beat;
  logic [10:0]        win_len;
  logic               unused_busy;

  assign unused_busy = bus.usb_is_busy;
  assign beat = dir_q ? bus.output_valid
                      : bus.write_ready;

  always_comb begin
    cand = bus.req_valid;
`ifdef USB_ARB_PRIO_EN
    cand[0] = 1'b0;
`endif
    win_ok = 1'b0;
    win    = '0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IW'((int'(rr_q) + k) % NUM_REQ);
      if (!win_ok && cand[idx]) begin
        win_ok = 1'b1;
        win    = idx;
      end
    end
`ifdef USB_ARB_PRIO_EN
    if (bus.req_valid[0]) begin
      win_ok = 1'b1;
      win    = '0;
    end
`endif
    win_oh      = '0;
    win_oh[win] = 1'b1;
    win_len     = bus.req_len[int'(win)*11 +: 11];
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    err_d   = 1'b0;
    en_d    = en_q;
    num_d   = num_q;
    len_d   = len_q;
    beat_d  = beat_q;
    wd_d    = wd_q;
    gap_d   = gap_q;
    rr_d    = rr_q;
    dir_d   = dir_q;
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        if (|bus.req_valid) state_d = ARB;
      end
      ARB: begin
        if (win_ok) begin
          grant_d = win_oh;
          dir_d   = bus.req_dir[win];
          len_d   = win_len;
          beat_d  = '0;
          wd_d    = '0;
          gap_d   = '0;
`ifdef USB_ARB_PRIO_EN
          if (win != '0)
            rr_d = IW'((int'(win) + 1) % NUM_REQ);
`else
          rr_d = IW'((int'(win) + 1) % NUM_REQ);
`endif
          if (win_len == '0) begin
            done_d  = win_oh;
            state_d = GAP;
          end else begin
            en_d    = bus.req_dir[win] ? 2'b10
                                       : 2'b01;
            num_d   = win_len;
            state_d = XFER;
          end
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        if (beat) begin
          wd_d = '0;
          if (beat_q != 11'h7FF)
            beat_d = beat_q + 11'd1;
          if (beat_d == len_q) begin
            en_d    = 2'b00;
            done_d  = grant_q;
            gap_d   = '0;
            state_d = GAP;
          end
        end else begin
          if (wd_q != 16'hFFFF)
            wd_d = wd_q + 16'd1;
          // Silence long enough: abort the burst.
          if (wd_q == 16'(TIMEOUT_CYC - 1)) begin
            en_d    = 2'b00;
            done_d  = grant_q;
            err_d   = 1'b1;
            gap_d   = '0;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        grant_d = '0;
        gap_d   = gap_q + 8'd1;
        if (gap_q == 8'(GAP_CYC - 1))
          state_d = (|bus.req_valid) ? ARB
                                     : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      en_q    <= 2'b00;
      num_q   <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      wd_q    <= '0;
      gap_q   <= '0;
      rr_q    <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      en_q    <= en_d;
      num_q   <= num_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      wd_q    <= wd_d;
      gap_q   <= gap_d;
      rr_q    <= rr_d;
      dir_q   <= dir_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.done        = done_q;
  assign bus.err_timeout = err_q;
  assign bus.rd_wr_en    = en_q;
  assign bus.rd_wr_num   = num_q;
endmodule

// File: tb/tb_usb_xfer_arb.sv
// tb_usb_xfer_arb: directed checks of usb_xfer_arb arbitration,
// burst sequencing, gap timing, watchdog and reset.
module tb_usb_xfer_arb;
  localparam int N   = 4;
  localparam int TO  = 32;
  localparam int GAP = 4;
`ifdef USB_ARB_PRIO_EN
  localparam int RR_N = 6;
`else
  localparam int RR_N = 5;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vec   = 0;
  int   errs  = 0;

  usb_xfer_arb_if #(.NUM_REQ(N)) bus ();

  usb_xfer_arb #(
    .NUM_REQ    (N),
    .TIMEOUT_CYC(TO),
    .GAP_CYC    (GAP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic set_req(input int i,
                         input logic dir,
                         input logic [10:0] len);
    bus.req_valid[i]         = 1'b1;
    bus.req_dir[i]           = dir;
    bus.req_len[i*11 +: 11]  = len;
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 64; c++) begin
      tick;
      if (bus.grant != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle;
    repeat (12) tick;
  endtask

  task automatic test_reset;
    rst_n            = 1'b0;
    bus.req_valid    = '0;
    bus.req_dir      = '0;
    bus.req_len      = '0;
    bus.usb_is_busy  = 1'b0;
    bus.output_valid = 1'b0;
    bus.write_ready  = 1'b0;
    repeat (2) tick;
    vec++;
    if (bus.grant !== 4'b0000) begin
      errs++;
      $display("FAIL rst_grant got %b want 0000", bus.grant);
    end
    vec++;
    if (bus.done !== 4'b0000) begin
      errs++;
      $display("FAIL rst_done got %b want 0000", bus.done);
    end
    vec++;
    if (bus.err_timeout !== 1'b0) begin
      errs++;
      $display("FAIL rst_err got %b want 0", bus.err_timeout);
    end
    vec++;
    if (bus.rd_wr_en !== 2'b00) begin
      errs++;
      $display("FAIL rst_en got %b want 00", bus.rd_wr_en);
    end
    vec++;
    if (bus.rd_wr_num !== 11'd0) begin
      errs++;
      $display("FAIL rst_num got %0d want 0", bus.rd_wr_num);
    end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_write_burst;
    bit ok;
    bit early;
    bit gap_bad;
    set_req(1, 1'b0, 11'd8);
    wait_grant(ok);
    vec++;
    if (!ok || bus.grant !== 4'b0010) begin
      errs++;
      $display("FAIL wr_grant got %b want 0010", bus.grant);
    end
    vec++;
    if (bus.rd_wr_en !== 2'b01 || bus.rd_wr_num !== 11'd8) begin
      errs++;
      $display("FAIL wr_cmd got %b/%0d want 01/8",
               bus.rd_wr_en, bus.rd_wr_num);
    end
    early = 1'b0;
    for (int b = 0; b < 8; b++) begin
      bus.write_ready = 1'b1;
      tick;
      if (b < 7 && bus.done != '0) early = 1'b1;
    end
    bus.write_ready = 1'b0;
    vec++;
    if (early) begin
      errs++;
      $display("FAIL wr_early_done got 1 want 0");
    end
    vec++;
    if (bus.done !== 4'b0010 || bus.rd_wr_en !== 2'b00 ||
        bus.err_timeout !== 1'b0) begin
      errs++;
      $display("FAIL wr_done got %b/%b/%b want 0010/00/0",
               bus.done, bus.rd_wr_en, bus.err_timeout);
    end
    bus.req_valid[1] = 1'b0;
    set_req(0, 1'b1, 11'd1);
    gap_bad = 1'b0;
    for (int g = 1; g < 5; g++) begin
      tick;
      if (bus.grant != '0 || bus.rd_wr_en != 2'b00)
        gap_bad = 1'b1;
    end
    tick;
    vec++;
    if (gap_bad) begin
      errs++;
      $display("FAIL gap_quiet got 1 want 0");
    end
    vec++;
    if (bus.grant !== 4'b0001 || bus.rd_wr_en !== 2'b10 ||
        bus.rd_wr_num !== 11'd1) begin
      errs++;
      $display("FAIL gap_len got %b/%b/%0d want 0001/10/1",
               bus.grant, bus.rd_wr_en, bus.rd_wr_num);
    end
    bus.output_valid = 1'b1;
    tick;
    bus.output_valid = 1'b0;
    vec++;
    if (bus.done !== 4'b0001) begin
      errs++;
      $display("FAIL rd1_done got %b want 0001", bus.done);
    end
    bus.req_valid[0] = 1'b0;
    wait_idle;
  endtask

  task automatic test_zero_len;
    bit ok;
    bit bad;
    set_req(2, 1'b0, 11'd0);
    set_req(3, 1'b0, 11'd1);
    wait_grant(ok);
    vec++;
    if (!ok || bus.grant !== 4'b0100 || bus.done !== 4'b0100 ||
        bus.rd_wr_en !== 2'b00) begin
      errs++;
      $display("FAIL z_grant got %b/%b/%b want 0100/0100/00",
               bus.grant, bus.done, bus.rd_wr_en);
    end
    bus.req_valid[2] = 1'b0;
    bad = 1'b0;
    for (int g = 1; g < 5; g++) begin
      tick;
      if (bus.grant != '0 || bus.done != '0 ||
          bus.rd_wr_en != 2'b00)
        bad = 1'b1;
    end
    tick;
    vec++;
    if (bad) begin
      errs++;
      $display("FAIL z_gap got 1 want 0");
    end
    vec++;
    if (bus.grant !== 4'b1000 || bus.rd_wr_en !== 2'b01) begin
      errs++;
      $display("FAIL z_next got %b/%b want 1000/01",
               bus.grant, bus.rd_wr_en);
    end
    bus.write_ready = 1'b1;
    tick;
    bus.write_ready = 1'b0;
    vec++;
    if (bus.done !== 4'b1000) begin
      errs++;
      $display("FAIL z_done got %b want 1000", bus.done);
    end
    bus.req_valid[3] = 1'b0;
    wait_idle;
  endtask

  task automatic test_rr_order;
    int got [8];
    int want [6];
    int n;
    int id;
    logic [N-1:0] prev;
`ifdef USB_ARB_PRIO_EN
    want = '{0, 1, 0, 2, 0, 3};
`else
    want = '{0, 1, 2, 3, 0, 0};
`endif
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 11'd2);
    n    = 0;
    prev = '0;
    for (int c = 0; c < 400; c++) begin
      tick;
      bus.write_ready = (bus.rd_wr_en == 2'b01);
      if (bus.grant != '0 && bus.grant != prev) begin
        id = 0;
        for (int i = 0; i < N; i++)
          if (bus.grant[i]) id = i;
        if (n < 8) got[n] = id;
        if (id != 0 && n < RR_N - 1)
          bus.req_valid[0] = 1'b1;
        n++;
      end
      prev = bus.grant;
      for (int i = 0; i < N; i++)
        if (bus.done[i]) bus.req_valid[i] = 1'b0;
      if (bus.req_valid == '0) break;
    end
    bus.write_ready = 1'b0;
    vec++;
    if (n != RR_N) begin
      errs++;
      $display("FAIL rr_count got %0d want %0d", n, RR_N);
    end
    for (int k = 0; k < RR_N; k++) begin
      vec++;
      if (k < n && got[k] != want[k]) begin
        errs++;
        $display("FAIL rr_order[%0d] got %0d want %0d",
                 k, got[k], want[k]);
      end
    end
    wait_idle;
  endtask

  task automatic test_timeout;
    bit ok;
    int c;
    set_req(1, 1'b1, 11'd5);
    wait_grant(ok);
    vec++;
    if (!ok || bus.rd_wr_en !== 2'b10) begin
      errs++;
      $display("FAIL to_cmd got %b want 10", bus.rd_wr_en);
    end
    for (int b = 0; b < 3; b++) begin
      bus.output_valid = 1'b1;
      tick;
    end
    bus.output_valid = 1'b0;
    c = 1;
    while (c < TO + 10 && !bus.err_timeout) begin
      tick;
      c++;
    end
    vec++;
    if (c != TO + 1) begin
      errs++;
      $display("FAIL to_delay got %0d want %0d", c - 1, TO);
    end
    vec++;
    if (bus.done !== 4'b0010 || bus.rd_wr_en !== 2'b00) begin
      errs++;
      $display("FAIL to_done got %b/%b want 0010/00",
               bus.done, bus.rd_wr_en);
    end
    bus.req_valid[1] = 1'b0;
    wait_idle;
  endtask

  task automatic test_spurious;
    bit ok;
    bit early;
    bit bad;
    set_req(2, 1'b0, 11'd3);
    wait_grant(ok);
    bus.output_valid = 1'b1;
    early = 1'b0;
    for (int w = 0; w < 3; w++) begin
      bus.write_ready = 1'b1;
      tick;
      bus.write_ready = 1'b0;
      if (w < 2) begin
        if (bus.done != '0) early = 1'b1;
        tick;
        if (bus.done != '0) early = 1'b1;
      end
    end
    vec++;
    if (!ok || early) begin
      errs++;
      $display("FAIL sp_early got %b want 0", early);
    end
    vec++;
    if (bus.done !== 4'b0100) begin
      errs++;
      $display("FAIL sp_done got %b want 0100", bus.done);
    end
    bus.req_valid[2] = 1'b0;
    bus.write_ready  = 1'b1;
    bad = 1'b0;
    for (int g = 0; g < 8; g++) begin
      tick;
      if (bus.done != '0 || bus.err_timeout ||
          bus.rd_wr_en != 2'b00)
        bad = 1'b1;
    end
    vec++;
    if (bad) begin
      errs++;
      $display("FAIL sp_gap got 1 want 0");
    end
    bus.output_valid = 1'b0;
    bus.write_ready  = 1'b0;
    wait_idle;
  endtask

  task automatic test_reset_mid;
    bit ok;
    set_req(0, 1'b0, 11'd10);
    wait_grant(ok);
    vec++;
    if (!ok || bus.grant !== 4'b0001) begin
      errs++;
      $display("FAIL rm_grant got %b want 0001", bus.grant);
    end
    set_req(3, 1'b0, 11'd1);
    for (int b = 0; b < 2; b++) begin
      bus.write_ready = 1'b1;
      tick;
    end
    bus.write_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    vec++;
    if (bus.rd_wr_en !== 2'b00 || bus.grant !== 4'b0000) begin
      errs++;
      $display("FAIL rm_async got %b/%b want 00/0000",
               bus.rd_wr_en, bus.grant);
    end
    bus.write_ready = 1'b0;
    tick;
    vec++;
    if (bus.done !== 4'b0000 || bus.rd_wr_num !== 11'd0 ||
        bus.err_timeout !== 1'b0) begin
      errs++;
      $display("FAIL rm_regs got %b/%0d/%b want 0000/0/0",
               bus.done, bus.rd_wr_num, bus.err_timeout);
    end
    rst_n = 1'b1;
    wait_grant(ok);
    vec++;
    if (!ok || bus.grant !== 4'b0001 || bus.rd_wr_en !== 2'b01 ||
        bus.rd_wr_num !== 11'd10) begin
      errs++;
      $display("FAIL rm_rearb got %b/%b/%0d want 0001/01/10",
               bus.grant, bus.rd_wr_en, bus.rd_wr_num);
    end
    bus.write_ready = 1'b1;
    repeat (10) tick;
    bus.write_ready = 1'b0;
    vec++;
    if (bus.done !== 4'b0001) begin
      errs++;
      $display("FAIL rm_done got %b want 0001", bus.done);
    end
    bus.req_valid = '0;
    wait_idle;
  endtask

  initial begin
    test_reset;
    test_write_burst;
    test_zero_len;
    test_rr_order;
    test_timeout;
    test_spurious;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==",
             vec, errs);
    $finish;
  end
endmodule
